// File: rtl/ibex_pkg.sv
// Shared types for the RVFI trace path: the compact per-retirement record
// that the trace buffer stores and streams to the sink.
package ibex_pkg;

    localparam int unsigned TraceRecW = 104;

    // Field order matches the wire format, MSB first.
    typedef struct packed {
        logic        gap;
        logic        intr;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] insn;
        logic [31:0] pc;
    } ibex_trace_rec_t;

endpackage

// File: rtl/ibex_trace_fifo.sv
// Generic single-clock FIFO with registered head output, no fall-through.
// Storage is reset so the head reads as zero after reset.
module ibex_trace_fifo #(
    parameter int unsigned Width = 104,
    parameter int unsigned Depth = 8,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned LvlW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LvlW-1:0]  level_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LvlW'(Depth));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Captures one record per RVFI retirement into a FIFO and streams it to a
// back-pressured trace sink, counting and flagging records lost to overflow.
module ibex_rvfi_trace_buffer
    import ibex_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned DropCntW = 16,
    localparam int unsigned LvlW    = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 trace_en_i,
    input  logic                 flush_i,
    input  logic                 rvfi_valid_i,
    input  logic [31:0]          rvfi_insn_i,
    input  logic                 rvfi_trap_i,
    input  logic                 rvfi_intr_i,
    input  logic [31:0]          rvfi_pc_rdata_i,
    input  logic [4:0]           rvfi_rd_addr_i,
    input  logic [31:0]          rvfi_rd_wdata_i,
    output logic                 trace_valid_o,
    input  logic                 trace_ready_i,
    output logic [TraceRecW-1:0] trace_rec_o,
    output logic [LvlW-1:0]      level_o,
    output logic                 overflow_o,
    output logic [DropCntW-1:0]  drop_cnt_o
);

    ibex_trace_rec_t     wrec;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                cap;
    logic                push;
    logic                drop;
    logic                gap_set;
    logic                gap_pending_q;
    logic                overflow_q;
    logic [DropCntW-1:0] drop_cnt_q;

    assign pop     = trace_valid_o & trace_ready_i;
    assign cap     = rvfi_valid_i & trace_en_i & ~flush_i;
    assign push    = cap & (~fifo_full | pop);
    assign drop    = cap & ~push;
    assign gap_set = drop | (rvfi_valid_i & ~trace_en_i);

    always_comb begin
        wrec          = '0;
        wrec.gap      = gap_pending_q;
        wrec.intr     = rvfi_intr_i;
        wrec.trap     = rvfi_trap_i;
        wrec.rd_addr  = rvfi_rd_addr_i;
        wrec.rd_wdata = rvfi_rd_wdata_i;
        wrec.insn     = rvfi_insn_i;
        wrec.pc       = rvfi_pc_rdata_i;
    end

    ibex_trace_fifo #(
        .Width (TraceRecW),
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (wrec),
        .pop_i   (pop),
        .rdata_o (trace_rec_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign trace_valid_o = ~fifo_empty;

    // A set in the same cycle as a push wins, so the gap reaches the next record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gap_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else if (flush_i) begin
            gap_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            if (gap_set) begin
                gap_pending_q <= 1'b1;
            end else if (push) begin
                gap_pending_q <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DropCntW'(1);
                end
            end
        end
    end

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed bench for ibex_rvfi_trace_buffer; a second instance with a 2-bit
// drop counter shares the stimulus to exercise counter saturation.
module tb_ibex_rvfi_trace_buffer;

    logic         clk;
    logic         rst_n;
    logic         trace_en;
    logic         flush;
    logic         rvfi_valid;
    logic [31:0]  rvfi_insn;
    logic         rvfi_trap;
    logic         rvfi_intr;
    logic [31:0]  rvfi_pc;
    logic [4:0]   rvfi_rd_addr;
    logic [31:0]  rvfi_rd_wdata;
    logic         trace_ready;

    logic         trace_valid;
    logic [103:0] trace_rec;
    logic [3:0]   level;
    logic         overflow;
    logic [15:0]  drop_cnt;

    logic         trace_valid2;
    logic [103:0] trace_rec2;
    logic [3:0]   level2;
    logic         overflow2;
    logic [1:0]   drop_cnt2;

    int total = 0;
    int bad   = 0;

    ibex_rvfi_trace_buffer #(.Depth(8), .DropCntW(16)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .trace_en_i      (trace_en),
        .flush_i         (flush),
        .rvfi_valid_i    (rvfi_valid),
        .rvfi_insn_i     (rvfi_insn),
        .rvfi_trap_i     (rvfi_trap),
        .rvfi_intr_i     (rvfi_intr),
        .rvfi_pc_rdata_i (rvfi_pc),
        .rvfi_rd_addr_i  (rvfi_rd_addr),
        .rvfi_rd_wdata_i (rvfi_rd_wdata),
        .trace_valid_o   (trace_valid),
        .trace_ready_i   (trace_ready),
        .trace_rec_o     (trace_rec),
        .level_o         (level),
        .overflow_o      (overflow),
        .drop_cnt_o      (drop_cnt)
    );

    ibex_rvfi_trace_buffer #(.Depth(8), .DropCntW(2)) dut_sat (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .trace_en_i      (trace_en),
        .flush_i         (flush),
        .rvfi_valid_i    (rvfi_valid),
        .rvfi_insn_i     (rvfi_insn),
        .rvfi_trap_i     (rvfi_trap),
        .rvfi_intr_i     (rvfi_intr),
        .rvfi_pc_rdata_i (rvfi_pc),
        .rvfi_rd_addr_i  (rvfi_rd_addr),
        .rvfi_rd_wdata_i (rvfi_rd_wdata),
        .trace_valid_o   (trace_valid2),
        .trace_ready_i   (trace_ready),
        .trace_rec_o     (trace_rec2),
        .level_o         (level2),
        .overflow_o      (overflow2),
        .drop_cnt_o      (drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record fields are all derived from the PC so expectations can be rebuilt here.
    function automatic logic [103:0] expRec(input logic gap, input logic [31:0] pc);
        logic [31:0] insn;
        insn = pc ^ 32'h0001_3013;
        return {gap, pc[3], pc[2], pc[6:2], ~pc, insn, pc};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic en, input logic fl,
                                 input logic rdy, input logic [31:0] pc);
        rvfi_valid    = v;
        trace_en      = en;
        flush         = fl;
        trace_ready   = rdy;
        rvfi_pc       = pc;
        rvfi_insn     = pc ^ 32'h0001_3013;
        rvfi_intr     = pc[3];
        rvfi_trap     = pc[2];
        rvfi_rd_addr  = pc[6:2];
        rvfi_rd_wdata = ~pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        trace_en      = 1'b0;
        flush         = 1'b0;
        rvfi_valid    = 1'b0;
        rvfi_insn     = '0;
        rvfi_trap     = 1'b0;
        rvfi_intr     = 1'b0;
        rvfi_pc       = '0;
        rvfi_rd_addr  = '0;
        rvfi_rd_wdata = '0;
        trace_ready   = 1'b0;
        #12;
        checkOutput("rst_valid", trace_valid, 0);
        checkOutput("rst_rec", trace_rec, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        // Streaming with ready held high: each record appears one cycle after retirement.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 1, 32'h100 + 32'(4 * i));
            checkOutput("s1_valid", trace_valid, 1);
            checkOutput("s1_rec", trace_rec, expRec(0, 32'h100 + 32'(4 * i)));
            checkOutput("s1_level", level, 1);
        end
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s1_empty", level, 0);
        checkOutput("s1_valid_lo", trace_valid, 0);

        // Overfill: 10 retirements into 8 entries.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h200 + 32'(4 * i));
        end
        checkOutput("s2_level", level, 8);
        checkOutput("s2_drop", drop_cnt, 2);
        checkOutput("s2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("s2_drain", trace_rec, expRec(0, 32'h200 + 32'(4 * i)));
            applyStimulus(0, 1, 0, 1, 0);
        end
        checkOutput("s2_drained", level, 0);
        applyStimulus(1, 1, 0, 0, 32'h300);
        checkOutput("s2_gap1", trace_rec, expRec(1, 32'h300));
        applyStimulus(1, 1, 0, 0, 32'h304);
        checkOutput("s2_level2", level, 2);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s2_gap0", trace_rec, expRec(0, 32'h304));
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s2_empty", level, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h400 + 32'(4 * i));
        end
        checkOutput("s3_full", level, 8);
        applyStimulus(1, 1, 0, 1, 32'h480);
        checkOutput("s3_level", level, 8);
        checkOutput("s3_drop", drop_cnt, 2);
        for (int i = 1; i < 8; i++) begin
            checkOutput("s3_drain", trace_rec, expRec(0, 32'h400 + 32'(4 * i)));
            applyStimulus(0, 1, 0, 1, 0);
        end
        checkOutput("s3_last", trace_rec, expRec(0, 32'h480));
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("s3_empty", level, 0);

        // Retirements skipped while disabled mark the next record.
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("s4_flush_drop", drop_cnt, 0);
        checkOutput("s4_flush_ovf", overflow, 0);
        applyStimulus(1, 0, 0, 0, 32'h500);
        applyStimulus(1, 0, 0, 0, 32'h504);
        checkOutput("s4_level", level, 0);
        applyStimulus(1, 1, 0, 0, 32'h508);
        checkOutput("s4_gap", trace_rec, expRec(1, 32'h508));
        checkOutput("s4_drop", drop_cnt, 0);

        // Flush at level 5 with coincident retirement and pop; gap left pending first.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h50C + 32'(4 * i));
        end
        checkOutput("s5_level5", level, 5);
        applyStimulus(1, 0, 0, 0, 32'h51C);
        applyStimulus(1, 1, 1, 1, 32'h520);
        checkOutput("s5_level", level, 0);
        checkOutput("s5_valid", trace_valid, 0);
        checkOutput("s5_drop", drop_cnt, 0);
        checkOutput("s5_ovf", overflow, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("s5_still0", level, 0);
        applyStimulus(1, 1, 0, 0, 32'h524);
        checkOutput("s5_rec", trace_rec, expRec(0, 32'h524));
        checkOutput("s5_level1", level, 1);

        // Saturation: 13 retirements, 5 drops.
        applyStimulus(0, 1, 1, 0, 0);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, 1, 0, 0, 32'h600 + 32'(4 * i));
        end
        checkOutput("s6_drop16", drop_cnt, 5);
        checkOutput("s6_drop2", drop_cnt2, 3);
        checkOutput("s6_ovf2", overflow2, 1);
        checkOutput("s6_level2", level2, 8);
        applyStimulus(1, 1, 0, 0, 32'h700);
        checkOutput("s6_sat", drop_cnt2, 3);
        checkOutput("s6_drop16b", drop_cnt, 6);

        // Asynchronous reset away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", trace_valid, 0);
        checkOutput("ar_rec", trace_rec, 0);
        checkOutput("ar_level", level, 0);
        checkOutput("ar_ovf", overflow, 0);
        checkOutput("ar_drop", drop_cnt, 0);
        checkOutput("ar_drop2", drop_cnt2, 0);
        checkOutput("ar_rec2", trace_rec2, 0);
        #10;
        rst_n = 1'b1;
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("ar_after", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
